wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural register file at the write-back end of the 5-stage pipeline.
- Accepts the MEM/WB write (wb_wreg/wb_wd/wb_wdata) and serves the two ID read requests (reg1/reg2 read enable + address → data).
- Also carries a request/acknowledge debug read port and a committed-write counter, used by benches and the observer.

Parameters:
DATA_W, 16, register width (matches RegBus)
ADDR_W, 4, register address width (matches RegAddrBus)
NUM_REGS, 16, number of registers; must equal 2**ADDR_W
CNT_W, 16, width of committed-write counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
we  input  1  write enable from MEM/WB (wb_wreg)
waddr  input  ADDR_W  write register address (wb_wd)
wdata  input  DATA_W  write data (wb_wdata)
re1  input  1  read port 1 enable (ID reg1_read)
raddr1  input  ADDR_W  read port 1 address
rdata1  output  DATA_W  read port 1 data (ID reg1_data_in)
re2  input  1  read port 2 enable (ID reg2_read)
raddr2  input  ADDR_W  read port 2 address
rdata2  output  DATA_W  read port 2 data (ID reg2_data_in)
dbg_req  input  1  debug read request, level
dbg_addr  input  ADDR_W  debug read address, stable while dbg_req high
dbg_ack  output  1  debug acknowledge, one-cycle pulse
dbg_data  output  DATA_W  debug read data, valid when dbg_ack=1, held afterwards
wr_count  output  CNT_W  number of committed writes since reset

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - all registers cleared to 0; dbg_ack=0, dbg_data=0, wr_count=0; debug FSM to IDLE.
  - rdata1/rdata2 forced to 0 while rst=0.
- Register r0 is hardwired to 0:
  - writes to address 0 are discarded and do not count.
  - reads of address 0 return 0.
- Write, committed on the rising clk edge when we=1 and waddr!=0:
  - regs[waddr] <= wdata.
  - wr_count increments by 1 and saturates at all-ones (no wrap).
- Read ports are combinational, zero latency:
  - rdataN = 0 if reN=0 or raddrN=0.
  - otherwise rdataN = regs[raddrN], with the same-cycle bypass rule under Optional Feature.
  - Ports are independent; both ports may read the same address.
- Debug FSM:
  - IDLE: dbg_req=1 at a clk edge → dbg_data <= regs[dbg_addr] (array contents before any write at that edge; r0 gives 0). Next state ACK, dbg_ack=1.
  - ACK: lasts exactly one cycle; dbg_ack=0 at the next edge. Next state HOLD.
  - HOLD: stay until dbg_req=0 is sampled, then IDLE. A new request needs dbg_req to go low for at least one edge.
  - dbg_data holds its last value until the next capture.
  - Debug reads never block or delay pipeline reads or writes.
- Simultaneous events:
  - A write and both reads to the same address in one cycle is legal.
  - A write and a debug capture at the same edge is legal; the capture returns the old value.
- Reset mid-operation (dbg_ack high, or writes in flight): all state cleared at once; no write completes on the edge coinciding with rst=0.

Optional Feature:
Macro RF_WB_BYPASS_EN.
- Defined: when we=1, waddr!=0, reN=1 and raddrN==waddr, rdataN = wdata in the same cycle (write-through). ID then needs no WB-stage forwarding.
- Undefined: rdataN returns the pre-write array value; the new value is visible from the cycle after the edge. Software must space dependent instructions by one extra slot.

Test Plan:
1. Hold rst=0 for 4 cycles, release; read all 16 addresses on both ports with re=1 → all 0, wr_count=0, dbg_ack=0.
2. Write r3=0x0003, then r6=0x0006 on consecutive cycles; next cycle read re1/raddr1=3, re2/raddr2=6 → rdata1=0x0003, rdata2=0x0006, wr_count=2.
3. Write r0=0xFFFF with we=1 → read r0 returns 0x0000, wr_count unchanged; re1=0 with raddr1=3 → rdata1=0.
4. Same cycle: we=1, waddr=5, wdata=0x1234, raddr1=5 (old r5=0x0001):
   - With RF_WB_BYPASS_EN: rdata1=0x1234 in that cycle.
   - Without it: rdata1=0x0001, then 0x1234 the next cycle.
5. Debug: r9=0xBEEF; raise dbg_req with dbg_addr=9 and hold 5 cycles → exactly one dbg_ack pulse, one cycle after the sampling edge, dbg_data=0xBEEF held. Drop req 1 cycle, re-raise → second pulse.
6. Pull rst=0 asynchronously mid-cycle while dbg_ack=1 and we=1 → dbg_ack, wr_count and regs go to 0 immediately; after release, a debug read of r9 returns 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file, r0 hardwired to 0, req/ack debug read port, saturating write counter.
// Latency: reads are combinational, writes commit at the clk edge, dbg_ack pulses the cycle after req is sampled.
// Never stalls the pipeline. Debug req is level-based and re-arms only after it drops. Optional RF_WB_BYPASS_EN: write-through reads.
module wb_regfile #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              dbg_req,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);

   typedef enum logic [1:0] {
      DBG_IDLE = 2'd0,
      DBG_ACK  = 2'd1,
      DBG_HOLD = 2'd2
   } dbg_state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs [NUM_REGS];
   dbg_state_t        dbg_state, dbg_state_nxt;
   logic              dbg_cap;
   logic              wr_commit;
   logic              hit1, hit2;

   assign wr_commit = we && (waddr != '0);

   // Register array and committed-write counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         wr_count <= '0;
      end else if (wr_commit) begin
         regs[waddr] <= wdata;
         if (wr_count != '1) begin
            wr_count <= wr_count + CNT_ONE;
         end
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign hit1 = wr_commit && (waddr == raddr1);
   assign hit2 = wr_commit && (waddr == raddr2);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (rst && re1 && (raddr1 != '0)) begin
         rdata1 = hit1 ? wdata : regs[raddr1];
      end
      if (rst && re2 && (raddr2 != '0)) begin
         rdata2 = hit2 ? wdata : regs[raddr2];
      end
   end

   // Debug FSM: one capture and one ack per req assertion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dbg_state <= DBG_IDLE;
      end else begin
         dbg_state <= dbg_state_nxt;
      end
   end

   always_comb begin
      dbg_state_nxt = dbg_state;
      dbg_cap       = 1'b0;
      dbg_ack       = 1'b0;
      case (dbg_state)
         DBG_IDLE: begin
            if (dbg_req) begin
               dbg_cap       = 1'b1;
               dbg_state_nxt = DBG_ACK;
            end
         end
         DBG_ACK: begin
            dbg_ack       = 1'b1;
            dbg_state_nxt = DBG_HOLD;
         end
         DBG_HOLD: begin
            if (!dbg_req) begin
               dbg_state_nxt = DBG_IDLE;
            end
         end
         default: dbg_state_nxt = DBG_IDLE;
      endcase
   end

   // Capture sees the array before any write landing on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dbg_data <= '0;
      end else if (dbg_cap) begin
         dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table for write/read traffic, hand sequences for debug and async reset.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic        re1, re2;
   logic [3:0]  raddr1, raddr2;
   logic [15:0] rdata1, rdata2;
   logic        dbg_req;
   logic [3:0]  dbg_addr;
   logic        dbg_ack;
   logic [15:0] dbg_data;
   logic [15:0] wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   wb_regfile #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
      .dbg_data(dbg_data), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        re1;
      logic [3:0]  ra1;
      logic        re2;
      logic [3:0]  ra2;
      logic [15:0] e1;
      logic [15:0] e2;
      logic [15:0] ecnt;
   } vec_t;

   vec_t vt[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [15:0] byp_exp;
      bit          seen;

`ifdef RF_WB_BYPASS_EN
      byp_exp = 16'h1234;
`else
      byp_exp = 16'h0001;
`endif
      //          we    wa     wd        re1   ra1    re2   ra2    e1        e2        cnt
      vt[0] = '{1'b1, 4'd3, 16'h0003, 1'b0, 4'd3, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'd0};
      vt[1] = '{1'b1, 4'd6, 16'h0006, 1'b0, 4'd0, 1'b0, 4'd6, 16'h0000, 16'h0000, 16'd1};
      vt[2] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 4'd6, 16'h0003, 16'h0006, 16'd2};
      vt[3] = '{1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd3, 16'h0000, 16'h0003, 16'd2};
      vt[4] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd3, 1'b1, 4'd0, 16'h0000, 16'h0000, 16'd2};
      vt[5] = '{1'b1, 4'd5, 16'h0001, 1'b0, 4'd5, 1'b0, 4'd5, 16'h0000, 16'h0000, 16'd2};
      vt[6] = '{1'b1, 4'd9, 16'hBEEF, 1'b1, 4'd5, 1'b1, 4'd5, 16'h0001, 16'h0001, 16'd3};
      vt[7] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 1'b1, 4'd6, 16'hBEEF, 16'h0006, 16'd4};
      vt[8] = '{1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 1'b1, 4'd3, byp_exp,  16'h0003, 16'd4};
      vt[9] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 1'b1, 4'd9, 16'h1234, 16'hBEEF, 16'd5};

      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b1; raddr1 = 4'd3; re2 = 1'b1; raddr2 = 4'd6;
      dbg_req = 1'b0; dbg_addr = '0;

      // Reset held for 4 cycles
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_wr_count", wr_count, 0);
      check("rst_dbg_ack", dbg_ack, 0);
      check("rst_dbg_data", dbg_data, 0);
      check("rst_rdata1", rdata1, 0);
      rst = 1'b1;
      for (int a = 0; a < 16; a++) begin
         raddr1 = a[3:0];
         raddr2 = 4'(15 - a);
         #1;
         check($sformatf("clr_rd1[%0d]", a), rdata1, 0);
         check($sformatf("clr_rd2[%0d]", 15 - a), rdata2, 0);
      end
      @(posedge clk);

      // Table-driven write/read traffic
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
         re1 = vt[i].re1; raddr1 = vt[i].ra1;
         re2 = vt[i].re2; raddr2 = vt[i].ra2;
         #1;
         check($sformatf("vec%0d_rdata1", i), rdata1, vt[i].e1);
         check($sformatf("vec%0d_rdata2", i), rdata2, vt[i].e2);
         check($sformatf("vec%0d_wr_count", i), wr_count, vt[i].ecnt);
      end

      // Debug request held 5 cycles, with a same-edge write to r9
      @(negedge clk);
      we = 1'b1; waddr = 4'd9; wdata = 16'h1111;
      re1 = 1'b0; re2 = 1'b0;
      dbg_req = 1'b1; dbg_addr = 4'd9;
      #1;
      check("dbg_ack_before", dbg_ack, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         we = 1'b0;
         check($sformatf("dbg_ack_cyc%0d", c), dbg_ack, (c == 0) ? 1 : 0);
         check($sformatf("dbg_data_cyc%0d", c), dbg_data, 16'hBEEF);
      end
      check("dbg_wr_count", wr_count, 6);
      dbg_req = 1'b0;
      @(negedge clk);
      dbg_req = 1'b1;
      #1;
      check("dbg2_ack_pre", dbg_ack, 0);
      @(negedge clk);
      check("dbg2_ack", dbg_ack, 1);
      check("dbg2_data", dbg_data, 16'h1111);
      @(negedge clk);
      check("dbg2_ack_drop", dbg_ack, 0);
      dbg_req = 1'b0;
      @(negedge clk);

      // Async reset while dbg_ack high and a write pending
      dbg_req = 1'b1;
      @(negedge clk);
      check("pre_rst_ack", dbg_ack, 1);
      we = 1'b1; waddr = 4'd7; wdata = 16'h7777;
      re1 = 1'b1; raddr1 = 4'd9; re2 = 1'b1; raddr2 = 4'd7;
      #2;
      rst = 1'b0;
      #1;
      check("arst_dbg_ack", dbg_ack, 0);
      check("arst_wr_count", wr_count, 0);
      check("arst_dbg_data", dbg_data, 0);
      check("arst_rdata1", rdata1, 0);
      @(posedge clk);
      @(negedge clk);
      we = 1'b0; dbg_req = 1'b0;
      rst = 1'b1;
      #1;
      check("post_rst_r9", rdata1, 0);
      check("post_rst_r7", rdata2, 0);
      check("post_rst_wr_count", wr_count, 0);
      dbg_addr = 4'd9;
      dbg_req = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (dbg_ack) seen = 1'b1;
      end
      check("post_rst_dbg_ack_seen", seen, 1);
      check("post_rst_dbg_data", dbg_data, 0);
      dbg_req = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
